// File: rtl/int_controller.sv
// int_controller
//   Parametrised interrupt controller. Each request line is synchronised,
//   normalised to active-high, then edge- or level-detected to set a flag
//   (IF) bit. Flags masked by the enable register (IE) are arbitrated with
//   fixed priority (bit 0 highest). The winning vector is held stable until
//   it is acknowledged or withdrawn.
//
//   Ports:
//     clk, rst            clock; asynchronous active-high reset
//     src_req[NUM_SRC]    raw request lines
//     reg_sel             register select for CPU port (0 = IF, 1 = IE)
//     wr_en, wr_data[8]   single-cycle register write
//     rd_data[8]          combinational register read
//     int_req             interrupt presented to the datapath
//     int_idx[3]          index of the presented source
//     int_vector[8]       VEC_BASE + VEC_STRIDE*int_idx (mod 256)
//     int_ack             datapath accepts the presented interrupt
//     if_out[NUM_SRC]     current flag register
module int_controller #(
  parameter int unsigned NUM_SRC     = 5,
  parameter logic [7:0]  EDGE_MASK   = 8'h1C,
  parameter logic [7:0]  ACTIVE_LOW  = 8'h10,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  VEC_BASE    = 8'h40,
  parameter logic [7:0]  VEC_STRIDE  = 8'h08
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_req,
  input  logic               reg_sel,
  input  logic               wr_en,
  input  logic [7:0]         wr_data,
  output logic [7:0]         rd_data,
  output logic               int_req,
  output logic [2:0]         int_idx,
  output logic [7:0]         int_vector,
  input  logic               int_ack,
  output logic [NUM_SRC-1:0] if_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } state_e;

  localparam logic [NUM_SRC-1:0] EDGE_N = EDGE_MASK[NUM_SRC-1:0];
  localparam logic [NUM_SRC-1:0] AL_N   = ACTIVE_LOW[NUM_SRC-1:0];

  state_e             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [NUM_SRC-1:0] if_q, if_d;
  logic [NUM_SRC-1:0] ie_q, ie_d;
  logic [NUM_SRC-1:0] prev_q;
  logic [NUM_SRC-1:0] sync_out;
  logic [NUM_SRC-1:0] act, prev_act, ev;
  logic [NUM_SRC-1:0] pend, pend_next, ack_mask;
  logic [7:0]         pend_next_ext;
  logic [2:0]         winner;
  logic               if_wr, ie_wr, ack_take;
  logic [7:0]         pad_ones;
  logic               unused_wr;

  // Synchroniser; flops reset to the raw inactive level of each line
  if (SYNC_STAGES == 0) begin : g_nosync
    assign sync_out = src_req;
  end else begin : g_sync
    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= AL_N;
      end else begin
        sync_q[0] <= src_req;
        for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
  end

  // prev_q holds the raw synchronised level, so it is normalised here too
  assign act      = sync_out ^ AL_N;
  assign prev_act = prev_q ^ AL_N;
  assign ev       = (EDGE_N & act & ~prev_act) | (~EDGE_N & act);

  assign if_wr    = wr_en & ~reg_sel;
  assign ie_wr    = wr_en & reg_sel;
  assign ack_take = int_ack && (state_q == PRESENT);
  assign ack_mask = ack_take ? NUM_SRC'(8'h01 << idx_q) : '0;

  // Event set wins over CPU write, which wins over ack clear
  always_comb begin
    if_d = if_q;
    if (if_wr) if_d = wr_data[NUM_SRC-1:0];
    else       if_d = if_q & ~ack_mask;
    if_d = if_d | ev;
  end

  always_comb begin
    ie_d = ie_q;
    if (ie_wr) ie_d = wr_data[NUM_SRC-1:0];
  end

  assign pend          = if_q & ie_q;
  assign pend_next     = if_d & ie_d;
  assign pend_next_ext = 8'(pend_next);

  // Lowest set index wins
  always_comb begin
    winner = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (pend[NUM_SRC-1-i]) winner = 3'(NUM_SRC-1-i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= AL_N;
      if_q   <= '0;
      ie_q   <= '0;
    end else begin
      prev_q <= sync_out;
      if_q   <= if_d;
      ie_q   <= ie_d;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // FSM: next state. Withdrawal looks at next-cycle pend so that int_req
  // drops the cycle right after the write that removes the request.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (|pend) begin
          idx_d   = winner;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (int_ack)                     state_d = GAP;
        else if (!pend_next_ext[idx_q])  state_d = IDLE;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    int_req    = (state_q == PRESENT);
    int_idx    = idx_q;
    int_vector = VEC_BASE + VEC_STRIDE * {5'b0, idx_q};
  end

  assign pad_ones  = 8'hFF << NUM_SRC;
  assign rd_data   = reg_sel ? 8'(ie_q) : (8'(if_q) | pad_ones);
  assign if_out    = if_q;
  assign unused_wr = ^wr_data;

endmodule

// File: tb/tb_int_controller.sv
// Directed bench for int_controller with default parameters:
//   sources 0,1 level; 2,3,4 edge; source 4 active-low; 2 sync stages.
//   vectors: idx0 40, idx1 48, idx2 50, idx3 58, idx4 60.
module tb_int_controller;

  logic       clk;
  logic       rst;
  logic [4:0] src_req;
  logic       reg_sel;
  logic       wr_en;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       int_req;
  logic [2:0] int_idx;
  logic [7:0] int_vector;
  logic       int_ack;
  logic [4:0] if_out;

  int n_cmp = 0;
  int n_err = 0;

  int_controller #(
    .NUM_SRC    (5),
    .EDGE_MASK  (8'h1C),
    .ACTIVE_LOW (8'h10),
    .SYNC_STAGES(2),
    .VEC_BASE   (8'h40),
    .VEC_STRIDE (8'h08)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .src_req   (src_req),
    .reg_sel   (reg_sel),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .int_req   (int_req),
    .int_idx   (int_idx),
    .int_vector(int_vector),
    .int_ack   (int_ack),
    .if_out    (if_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic sel, input logic [7:0] data);
    reg_sel = sel;
    wr_data = data;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    src_req = 5'b10000;
    reg_sel = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    int_ack = 1'b0;

    // Reset state
    #3;
    check("rst_int_req", {7'b0, int_req}, 8'h00);
    check("rst_int_idx", {5'b0, int_idx}, 8'h00);
    check("rst_vector", int_vector, 8'h40);
    check("rst_if", {3'b0, if_out}, 8'h00);
    check("rst_rd_if", rd_data, 8'hE0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Edge source 2, single-cycle pulse
    wr(1'b1, 8'h04);
    check("ie_read", rd_data, 8'h04);
    src_req[2] = 1'b1;
    tick();
    src_req[2] = 1'b0;
    tick();
    check("e2_if_early", {3'b0, if_out}, 8'h00);
    tick();
    check("e2_if_set", {3'b0, if_out}, 8'h04);
    check("e2_req_idle", {7'b0, int_req}, 8'h00);
    tick();
    check("e2_req", {7'b0, int_req}, 8'h01);
    check("e2_idx", {5'b0, int_idx}, 8'h02);
    check("e2_vec", int_vector, 8'h50);
    ack();
    check("e2_if_clr", {3'b0, if_out}, 8'h00);
    check("e2_gap", {7'b0, int_req}, 8'h00);
    tick();
    tick();
    check("e2_stay_low", {7'b0, int_req}, 8'h00);

    // Level source 0 held high
    wr(1'b1, 8'h01);
    src_req[0] = 1'b1;
    tick(); tick(); tick();
    check("l0_if", {3'b0, if_out}, 8'h01);
    tick();
    check("l0_req", {7'b0, int_req}, 8'h01);
    check("l0_vec", int_vector, 8'h40);
    ack();
    check("l0_if_reset", {3'b0, if_out}, 8'h01);
    check("l0_gap", {7'b0, int_req}, 8'h00);
    tick();
    check("l0_idle", {7'b0, int_req}, 8'h00);
    tick();
    check("l0_rearm", {7'b0, int_req}, 8'h01);
    check("l0_rearm_vec", int_vector, 8'h40);
    src_req[0] = 1'b0;
    tick(); tick(); tick();
    wr(1'b0, 8'h00);
    check("l0_withdraw", {7'b0, int_req}, 8'h00);
    check("l0_if_zero", {3'b0, if_out}, 8'h00);

    // Priority / freeze
    wr(1'b1, 8'h1F);
    wr(1'b0, 8'h08);
    tick();
    check("pf_req", {7'b0, int_req}, 8'h01);
    check("pf_idx3", {5'b0, int_idx}, 8'h03);
    check("pf_vec3", int_vector, 8'h58);
    src_req[1] = 1'b1;
    tick(); tick(); tick();
    check("pf_if", {3'b0, if_out}, 8'h0A);
    check("pf_frozen_idx", {5'b0, int_idx}, 8'h03);
    check("pf_frozen_vec", int_vector, 8'h58);
    src_req[1] = 1'b0;
    ack();
    check("pf_if_after_ack", {3'b0, if_out}, 8'h02);
    tick();
    tick();
    check("pf_next_req", {7'b0, int_req}, 8'h01);
    check("pf_next_idx", {5'b0, int_idx}, 8'h01);
    check("pf_next_vec", int_vector, 8'h48);
    ack();
    check("pf_if_clear", {3'b0, if_out}, 8'h00);
    tick();
    tick();

    // Withdraw of idx 4 by CPU write
    wr(1'b0, 8'h10);
    tick();
    check("wd_req", {7'b0, int_req}, 8'h01);
    check("wd_vec", int_vector, 8'h60);
    wr(1'b0, 8'h00);
    check("wd_req_low", {7'b0, int_req}, 8'h00);
    check("wd_rd", rd_data, 8'hE0);

    // Set-wins: ack of idx 2 coincident with a new edge on source 2
    src_req[2] = 1'b1;
    tick();
    src_req[2] = 1'b0;
    tick();
    tick();
    tick();
    check("sw_idx2", {5'b0, int_idx}, 8'h02);
    src_req[2] = 1'b1;
    tick();
    src_req[2] = 1'b0;
    tick();
    ack();
    check("sw_if_kept", {3'b0, if_out}, 8'h04);
    tick();
    tick();
    check("sw_second_req", {7'b0, int_req}, 8'h01);
    check("sw_second_idx", {5'b0, int_idx}, 8'h02);
    ack();
    check("sw_if_done", {3'b0, if_out}, 8'h00);
    tick();
    tick();

    // Set-wins: CPU write IF=0 coincident with edge on source 3
    wr(1'b1, 8'h00);
    wr(1'b0, 8'h07);
    src_req[3] = 1'b1;
    tick();
    src_req[3] = 1'b0;
    tick();
    wr(1'b0, 8'h00);
    check("sw_wr_if", {3'b0, if_out}, 8'h08);
    check("sw_wr_rd", rd_data, 8'hE8);
    wr(1'b0, 8'h00);

    // Active-low joypad source 4
    wr(1'b1, 8'h10);
    check("jp_idle", {3'b0, if_out}, 8'h00);
    src_req[4] = 1'b0;
    tick(); tick(); tick();
    check("jp_if", {3'b0, if_out}, 8'h10);
    tick();
    check("jp_req", {7'b0, int_req}, 8'h01);
    check("jp_vec", int_vector, 8'h60);
    ack();
    tick();
    tick();
    check("jp_held_if", {3'b0, if_out}, 8'h00);
    check("jp_held_req", {7'b0, int_req}, 8'h00);
    src_req[4] = 1'b1;
    tick(); tick(); tick(); tick();
    check("jp_release", {3'b0, if_out}, 8'h00);

    // Reset asserted mid-PRESENT
    src_req[4] = 1'b0;
    tick(); tick(); tick(); tick();
    check("rp_req", {7'b0, int_req}, 8'h01);
    #2;
    rst = 1'b1;
    #1;
    check("rp_req_low", {7'b0, int_req}, 8'h00);
    check("rp_if", {3'b0, if_out}, 8'h00);
    reg_sel = 1'b1;
    #1;
    check("rp_ie", rd_data, 8'h00);
    check("rp_vec", int_vector, 8'h40);
    tick();
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
